// File: rtl/vga_capture_pkg.sv
// Shared types and constants for the VGA strip-capture peripheral.
package vga_capture_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StArmed    = 3'd1,
      StWaitLine = 3'd2,
      StWaitX    = 3'd3,
      StSample   = 3'd4,
      StDone     = 3'd5
   } cap_state_e;

   localparam logic [5:0] AddrCtrl       = 6'h00;
   localparam logic [5:0] AddrStatus     = 6'h04;
   localparam logic [5:0] AddrTargetY    = 6'h08;
   localparam logic [5:0] AddrTargetX    = 6'h0C;
   localparam logic [5:0] AddrStep       = 6'h10;
   localparam logic [5:0] AddrLineClocks = 6'h14;
   localparam logic [5:0] AddrFrameLines = 6'h18;
   localparam logic [5:0] AddrCapture    = 6'h20;

   localparam logic [9:0]  LineCntMax    = 10'h3FF;
   localparam logic [10:0] XCntMax       = 11'h7FF;
   localparam logic [11:0] LineClkMax    = 12'hFFF;
   localparam logic [10:0] FrameLinesMax = 11'h7FF;

endpackage

// File: rtl/vga_sync_edge.sv
// Polarity-corrects one sync input, registers it and emits leading/trailing edge pulses.
module vga_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sync_i,
   input  logic active_low_i,
   output logic lead_o,
   output logic trail_o
);

   logic sync_q, sync_prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q      <= 1'b0;
         sync_prev_q <= 1'b0;
      end else begin
         sync_q      <= sync_i ^ active_low_i;
         sync_prev_q <= sync_q;
      end
   end

   // Edges come from two registered samples so they appear one cycle after the input moves.
   assign lead_o  = sync_q & ~sync_prev_q;
   assign trail_o = ~sync_q & sync_prev_q;

endmodule

// File: rtl/tqvp_rejunity_vga_capture.sv
// TinyQV peripheral capturing a 1-bit pixel strip at a programmable (line, clock) position.
// LINE_CLOCKS / FRAME_LINES counters are built only when VGA_CAPTURE_MEASURE_EN is defined.
module tqvp_rejunity_vga_capture
   import vga_capture_pkg::*;
#(
   parameter int unsigned CAPTURE_BITS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   localparam int unsigned IdxW  = $clog2(CAPTURE_BITS);
   localparam int unsigned Words = CAPTURE_BITS / 32;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(CAPTURE_BITS - 1);

   cap_state_e              state_q;
   logic                    hs_low_q, vs_low_q;
   logic [2:0]              mask_q;
   logic [9:0]              target_y_q, line_cnt_q;
   logic [10:0]             target_x_q, x_cnt_q;
   logic [7:0]              step_q, step_cnt_q, step_eff;
   logic [IdxW-1:0]         bit_idx_q;
   logic [CAPTURE_BITS-1:0] capture_q;
   logic                    done_q, short_q, irq_q;
   logic                    hs_lead, hs_trail, vs_lead, vs_trail;
   logic                    wr_en, ctrl_wr, pixel;
   logic [11:0]             line_clocks;
   logic [10:0]             frame_lines;
   logic                    unused_bits;

   assign wr_en    = (data_write_n == 2'b10);
   assign ctrl_wr  = wr_en && (address == AddrCtrl);
   assign pixel    = |(ui_in[2:0] & mask_q);
   assign step_eff = (step_q == 8'd0) ? 8'd1 : step_q;

   assign uo_out         = 8'd0;
   assign data_ready     = 1'b1;
   assign user_interrupt = irq_q;
   assign unused_bits    = ^{ui_in[7], ui_in[4:3], data_in[31:11], data_read_n, vs_trail};

   vga_sync_edge u_hsync_edge (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .sync_i      (ui_in[6]),
      .active_low_i(hs_low_q),
      .lead_o      (hs_lead),
      .trail_o     (hs_trail)
   );

   vga_sync_edge u_vsync_edge (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .sync_i      (ui_in[5]),
      .active_low_i(vs_low_q),
      .lead_o      (vs_lead),
      .trail_o     (vs_trail)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_low_q   <= 1'b1;
         vs_low_q   <= 1'b1;
         mask_q     <= 3'b111;
         target_y_q <= '0;
         target_x_q <= '0;
         step_q     <= 8'd1;
      end else if (wr_en) begin
         case (address)
            AddrCtrl: begin
               hs_low_q <= data_in[2];
               vs_low_q <= data_in[3];
               mask_q   <= data_in[6:4];
            end
            AddrTargetY: target_y_q <= data_in[9:0];
            AddrTargetX: target_x_q <= data_in[10:0];
            AddrStep:    step_q     <= data_in[7:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         line_cnt_q <= '0;
         x_cnt_q    <= '0;
         step_cnt_q <= '0;
         bit_idx_q  <= '0;
         capture_q  <= '0;
         done_q     <= 1'b0;
         short_q    <= 1'b0;
         irq_q      <= 1'b0;
      end else if (ctrl_wr && data_in[1]) begin
         state_q <= StIdle;
         done_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else if (ctrl_wr && data_in[0]) begin
         state_q   <= StArmed;
         done_q    <= 1'b0;
         short_q   <= 1'b0;
         capture_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         if (ctrl_wr) irq_q <= 1'b0;
         unique case (state_q)
            StIdle: ;
            StArmed: begin
               if (vs_lead) begin
                  line_cnt_q <= '0;
                  state_q    <= StWaitLine;
               end
            end
            StWaitLine: begin
               if (hs_trail) begin
                  if (line_cnt_q == target_y_q) begin
                     x_cnt_q <= '0;
                     state_q <= StWaitX;
                  end else if (line_cnt_q != LineCntMax) begin
                     line_cnt_q <= line_cnt_q + 10'd1;
                  end
               end
            end
            StWaitX: begin
               if (hs_lead) begin
                  short_q <= 1'b1;
                  done_q  <= 1'b1;
                  irq_q   <= 1'b1;
                  state_q <= StDone;
               end else if (x_cnt_q == target_x_q) begin
                  capture_q[0] <= pixel;
                  bit_idx_q    <= IdxW'(1);
                  step_cnt_q   <= 8'd1;
                  state_q      <= StSample;
               end else if (x_cnt_q != XCntMax) begin
                  x_cnt_q <= x_cnt_q + 11'd1;
               end
            end
            StSample: begin
               // A new line arriving early truncates the strip; untaken bits stay 0.
               if (hs_lead) begin
                  short_q <= 1'b1;
                  done_q  <= 1'b1;
                  irq_q   <= 1'b1;
                  state_q <= StDone;
               end else if (step_cnt_q >= step_eff) begin
                  capture_q[bit_idx_q] <= pixel;
                  step_cnt_q           <= 8'd1;
                  if (bit_idx_q == LastIdx) begin
                     done_q  <= 1'b1;
                     irq_q   <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end else begin
                  step_cnt_q <= step_cnt_q + 8'd1;
               end
            end
            StDone: ;
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef VGA_CAPTURE_MEASURE_EN
   logic [11:0] clk_cnt_q, line_clocks_q;
   logic [10:0] hs_cnt_q, frame_lines_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt_q     <= '0;
         line_clocks_q <= '0;
         hs_cnt_q      <= '0;
         frame_lines_q <= '0;
      end else begin
         if (hs_lead) begin
            line_clocks_q <= clk_cnt_q;
            clk_cnt_q     <= 12'd1;
         end else if (clk_cnt_q != LineClkMax) begin
            clk_cnt_q <= clk_cnt_q + 12'd1;
         end
         // A line starting on the vsync edge itself belongs to the new frame.
         if (vs_lead) begin
            frame_lines_q <= hs_cnt_q;
            hs_cnt_q      <= {10'd0, hs_lead};
         end else if (hs_lead && hs_cnt_q != FrameLinesMax) begin
            hs_cnt_q <= hs_cnt_q + 11'd1;
         end
      end
   end

   assign line_clocks = line_clocks_q;
   assign frame_lines = frame_lines_q;
`else
   assign line_clocks = '0;
   assign frame_lines = '0;
`endif

   always_comb begin
      data_out = '0;
      case (address)
         AddrStatus:     data_out = {22'd0, short_q, done_q, 5'd0, state_q};
         AddrTargetY:    data_out = {22'd0, target_y_q};
         AddrTargetX:    data_out = {21'd0, target_x_q};
         AddrStep:       data_out = {24'd0, step_q};
         AddrLineClocks: data_out = {20'd0, line_clocks};
         AddrFrameLines: data_out = {21'd0, frame_lines};
         default: ;
      endcase
      for (int w = 0; w < int'(Words); w++) begin
         if (address == AddrCapture + 6'(4 * w)) data_out = capture_q[32*w +: 32];
      end
   end

endmodule

// File: tb/tb_tqvp_rejunity_vga_capture.sv
// Directed bench for tqvp_rejunity_vga_capture driving synthetic VGA frames on ui_in.
`timescale 1ns/1ps
module tb_tqvp_rejunity_vga_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ui_in, uo_out;
   logic [5:0]  address;
   logic [31:0] data_in, data_out;
   logic [1:0]  data_write_n, data_read_n;
   logic        data_ready, user_interrupt;

   int checks = 0;
   int errors = 0;

   // Synthetic frame shape and the strip expected on the target line
   int          line_len = 160;
   int          hs_len   = 8;
   int          n_lines  = 12;
   int          tgt_line = 2;
   int          x0       = 12;
   int          step     = 1;
   logic [63:0] pat      = 64'h5555_5555_5555_5555;
   logic        hs_high  = 1'b0;
   logic        vs_high  = 1'b0;
   logic        noise    = 1'b0;
   logic [31:0] rdata;

`ifdef VGA_CAPTURE_MEASURE_EN
   localparam logic [31:0] ExpLineClk = 32'd160;
   localparam logic [31:0] ExpFrames  = 32'd12;
`else
   localparam logic [31:0] ExpLineClk = 32'd0;
   localparam logic [31:0] ExpFrames  = 32'd0;
`endif

   always #5 clk = ~clk;

   tqvp_rejunity_vga_capture dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ui_in         (ui_in),
      .uo_out        (uo_out),
      .address       (address),
      .data_in       (data_in),
      .data_write_n  (data_write_n),
      .data_read_n   (data_read_n),
      .data_out      (data_out),
      .data_ready    (data_ready),
      .user_interrupt(user_interrupt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      #1;
      d = data_out;
   endtask

   task automatic rd_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(tag, d, exp);
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      address      = a;
      data_in      = d;
      data_write_n = 2'b10;
      @(posedge clk);
      #1;
      data_write_n = 2'b11;
   endtask

   task automatic set_idle();
      @(posedge clk);
      #1;
      ui_in = {1'b0, hs_high ? 1'b0 : 1'b1, vs_high ? 1'b0 : 1'b1, 5'd0};
   endtask

   // Drives frame cycles t0..t1-1; vsync is active for one line length starting at line 0, clock 4.
   task automatic drive(input int t0, input int t1);
      for (int t = t0; t < t1; t++) begin
         int   l = t / line_len;
         int   c = t % line_len;
         int   p, k;
         logic hs, vs, b;
         hs = (c < hs_len);
         vs = (l == 0 && c >= 4) || (l == 1 && c < 4);
         b  = 1'b0;
         if (!hs) begin
            if (l != tgt_line) begin
               b = 1'b1;
            end else begin
               p = c - hs_len;
               if (p < x0) begin
                  b = ~pat[0];
               end else begin
                  k = (p - x0) / step;
                  if (k > 63) b = ~pat[63];
                  else b = ((p - x0) % step == 0) ? pat[k] : ~pat[k];
               end
            end
         end
         @(posedge clk);
         #1;
         ui_in = {1'b0, hs ^ ~hs_high, vs ^ ~vs_high, 2'b00, noise & ~b, b, noise & ~b};
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      ui_in        = 8'h60;
      address      = '0;
      data_in      = '0;
      data_write_n = 2'b11;
      data_read_n  = 2'b11;
      repeat (3) @(posedge clk);

      // Reset values
      rd_check("rst_status", 6'h04, 32'h0);
      rd_check("rst_ctrl_rd", 6'h00, 32'h0);
      rd_check("rst_tgt_y", 6'h08, 32'h0);
      rd_check("rst_tgt_x", 6'h0C, 32'h0);
      rd_check("rst_step", 6'h10, 32'h1);
      rd_check("rst_line_clk", 6'h14, 32'h0);
      rd_check("rst_frame", 6'h18, 32'h0);
      rd_check("rst_cap0", 6'h20, 32'h0);
      rd_check("rst_cap1", 6'h24, 32'h0);
      check("rst_irq", {31'd0, user_interrupt}, 32'h0);
      check("rst_uo_out", {24'd0, uo_out}, 32'h0);
      check("data_ready", {31'd0, data_ready}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // Register readback and width masking
      wr(6'h08, 32'd2);
      wr(6'h0C, 32'hFFFF_FFFF);
      rd_check("tgt_x_mask", 6'h0C, 32'h7FF);
      wr(6'h0C, 32'd10);
      wr(6'h10, 32'd1);
      rd_check("tgt_y_rb", 6'h08, 32'd2);
      rd_check("tgt_x_rb", 6'h0C, 32'd10);
      rd_check("unmapped", 6'h1C, 32'h0);

      // Alternating strip on line 2, two frames for measurement
      wr(6'h00, 32'h7D);
      rd_check("armed", 6'h04, 32'h1);
      drive(0, line_len * n_lines);
      drive(0, line_len * n_lines);
      rd_check("alt_cap0", 6'h20, 32'h5555_5555);
      rd_check("alt_cap1", 6'h24, 32'h5555_5555);
      rd_check("alt_status", 6'h04, 32'h105);
      check("alt_irq", {31'd0, user_interrupt}, 32'h1);
      rd_check("line_clocks", 6'h14, ExpLineClk);
      rd_check("frame_lines", 6'h18, ExpFrames);

      // STEP=4 overruns the line: bits 0..34 taken, bit 35 lands in hsync, rest untaken
      step = 4;
      pat  = '1;
      wr(6'h10, 32'd4);
      wr(6'h00, 32'h7D);
      rd_check("restart_status", 6'h04, 32'h1);
      rd_check("restart_cap0", 6'h20, 32'h0);
      check("restart_irq", {31'd0, user_interrupt}, 32'h0);
      drive(0, 4 * line_len + 10);
      rd_check("short_status", 6'h04, 32'h305);
      rd_check("short_cap0", 6'h20, 32'hFFFF_FFFF);
      rd_check("short_cap1", 6'h24, 32'h0000_0007);
      check("short_irq", {31'd0, user_interrupt}, 32'h1);

      // Abort from DONE keeps CAPTURE
      wr(6'h00, 32'h7E);
      rd(6'h04, rdata);
      check("abort_done_state", rdata & 32'h1FF, 32'h0);
      rd_check("abort_keep_cap0", 6'h20, 32'hFFFF_FFFF);
      check("abort_irq", {31'd0, user_interrupt}, 32'h0);

      // Abort during WAIT_LINE, then no completion for the rest of the frame
      step = 1;
      pat  = 64'h5555_5555_5555_5555;
      wr(6'h10, 32'd1);
      wr(6'h00, 32'h7D);
      drive(0, line_len + 20);
      rd_check("wait_line", 6'h04, 32'h2);
      wr(6'h00, 32'h7E);
      rd_check("abort_wl", 6'h04, 32'h0);
      drive(line_len + 20, line_len * n_lines);
      rd_check("abort_stays", 6'h04, 32'h0);
      check("abort_wl_irq", {31'd0, user_interrupt}, 32'h0);

      // Start and abort together
      wr(6'h00, 32'h7D);
      rd_check("armed_again", 6'h04, 32'h1);
      wr(6'h00, 32'h7F);
      rd_check("start_abort", 6'h04, 32'h0);

      // Active-high syncs with pixel on ui_in[1] only (mask 010), noise on [0] and [2]
      hs_high = 1'b1;
      vs_high = 1'b1;
      noise   = 1'b1;
      set_idle();
      wr(6'h00, 32'h21);
      rd_check("hi_armed", 6'h04, 32'h1);
      drive(0, line_len * n_lines);
      rd_check("hi_cap0", 6'h20, 32'h5555_5555);
      rd_check("hi_cap1", 6'h24, 32'h5555_5555);
      rd_check("hi_status", 6'h04, 32'h105);

      // Reset in the middle of SAMPLE
      hs_high = 1'b0;
      vs_high = 1'b0;
      noise   = 1'b0;
      pat     = 64'hF0E1_D2C3_B4A5_9687;
      set_idle();
      wr(6'h00, 32'h7D);
      drive(0, 2 * line_len + 48);
      rd_check("mid_sample", 6'h04, 32'h4);
      rst_n = 1'b0;
      rd_check("mr_status", 6'h04, 32'h0);
      rd_check("mr_cap0", 6'h20, 32'h0);
      rd_check("mr_tgt_y", 6'h08, 32'h0);
      rd_check("mr_tgt_x", 6'h0C, 32'h0);
      rd_check("mr_step", 6'h10, 32'h1);
      rd_check("mr_line_clk", 6'h14, 32'h0);
      check("mr_irq", {31'd0, user_interrupt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fresh capture after reset, STEP=0 behaves as 1
      wr(6'h08, 32'd2);
      wr(6'h0C, 32'd10);
      wr(6'h10, 32'd0);
      rd_check("step_zero_rb", 6'h10, 32'h0);
      wr(6'h00, 32'h7D);
      drive(0, line_len * n_lines);
      rd_check("post_cap0", 6'h20, 32'hB4A5_9687);
      rd_check("post_cap1", 6'h24, 32'hF0E1_D2C3);
      rd_check("post_status", 6'h04, 32'h105);
      check("post_irq", {31'd0, user_interrupt}, 32'h1);

      // Any CTRL write clears the interrupt without start/abort
      wr(6'h00, 32'h7C);
      check("ctrl_wr_irq", {31'd0, user_interrupt}, 32'h0);
      rd_check("ctrl_wr_state", 6'h04, 32'h105);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
